// File: rtl/pattern_scan_display_pkg.sv
// Shared constants and helpers for the multi-digit pattern scan display.
package pattern_scan_display_pkg;

    localparam int unsigned SEG_W_DEFAULT = 7;

    // Anode polarity choices for the AN_ACTIVE_LOW parameter.
    localparam bit AN_POL_ACTIVE_HIGH = 1'b0;
    localparam bit AN_POL_ACTIVE_LOW  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/pattern_scan_display_tick_divider.sv
// Enable-gated modulo-DIV counter producing a one-cycle tick on its last count.
module tick_divider
    import pattern_scan_display_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned W    = cnt_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Tick is combinational so the step lands on the same edge the count wraps.
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_scan_display.sv
// Steps a base segment pattern through its full space and time-multiplexes
// N_DIGITS digits, digit d showing base + d.
module pattern_scan_display
    import pattern_scan_display_pkg::*;
#(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned SEG_W         = SEG_W_DEFAULT,
    parameter int unsigned TICK_DIV      = 100_000_000,
    parameter int unsigned SCAN_DIV      = 100_000,
    parameter bit          AN_ACTIVE_LOW = AN_POL_ACTIVE_LOW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                dir,
    input  logic                step,
    output logic [SEG_W-1:0]    seg,
    output logic [N_DIGITS-1:0] an,
    output logic [SEG_W-1:0]    base,
    output logic                wrap
);

    localparam int unsigned          IDX_W    = cnt_width(N_DIGITS);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [SEG_W-1:0]     BASE_MAX = '1;
    localparam logic [N_DIGITS-1:0]  AN_SEL0  = N_DIGITS'(1);
    localparam logic [N_DIGITS-1:0]  AN_RESET = AN_ACTIVE_LOW ? ~AN_SEL0 : AN_SEL0;

    logic                pat_tick;
    logic                scan_tick;
    logic                step_q;
    logic [IDX_W-1:0]    idx;
    logic                step_evt;
    logic                wrap_hit;
    logic [SEG_W-1:0]    base_next;
    logic [SEG_W-1:0]    seg_next;
    logic [N_DIGITS-1:0] onehot;
    logic [N_DIGITS-1:0] an_next;

    tick_divider #(.DIV(TICK_DIV)) u_pat_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .tick  (pat_tick)
    );

    tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .tick  (scan_tick)
    );

    always_comb begin
        // Manual edges only count while paused; auto ticks only while running.
        step_evt  = run ? pat_tick : (step & ~step_q);
        base_next = dir ? base + 1'b1 : base - 1'b1;
        wrap_hit  = dir ? (base == BASE_MAX) : (base == '0);
        seg_next  = base + SEG_W'(idx);
        onehot    = '0;
        for (int unsigned d = 0; d < N_DIGITS; d++) begin
            onehot[d] = (idx == IDX_W'(d));
        end
        an_next = AN_ACTIVE_LOW ? ~onehot : onehot;
    end

    // seg and an share one register stage so they always describe the same digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q <= 1'b0;
            base   <= '0;
            wrap   <= 1'b0;
            idx    <= '0;
            seg    <= '0;
            an     <= AN_RESET;
        end else begin
            step_q <= step;
            wrap   <= step_evt && wrap_hit;
            if (step_evt) begin
                base <= base_next;
            end
            if (scan_tick) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule
